// File: rtl/sap_control_sequencer.sv
// ---------------------------------------------------------------------------
// sap_control_sequencer
//
// Control unit for a SAP-style accumulator machine. A one-hot ring counter
// walks the T-states; a combinational decoder turns the current T-state and
// the instruction-register opcode into the datapath control word.
//
// Extras over the classic SAP-1 sequencer: JMP, illegal-opcode flagging,
// a latched HALT state that only an asynchronous clear releases, and a
// single-step mode driven by the rising edge of a step request.
//
// Parameters
//   OP_W      opcode width; the opcodes below are zero-extended to OP_W
//   T_STATES  ring length (6 or more); T7..Tn decode as NOP
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   low_clr     asynchronous active-low clear
//   op_code     opcode field of the instruction register, stable from T4
//   step_en     1 = single-step mode
//   step        step request (level); its rising edge advances one T-state
//   cw          control word, active-high:
//               [12]cp [11]ep [10]lm [9]ce [8]li [7]ei [6]la [5]ea
//               [4]su  [3]eu  [2]lb  [1]lo [0]lp
//   t_state     one-hot current T-state, bit 0 = T1
//   low_halt    0 while halted
//   illegal_op  1 during T4 of an undefined opcode
// ---------------------------------------------------------------------------
module sap_control_sequencer #(
    parameter int OP_W     = 4,
    parameter int T_STATES = 6
) (
    input  logic                clk,
    input  logic                low_clr,
    input  logic [OP_W-1:0]     op_code,
    input  logic                step_en,
    input  logic                step,
    output logic [12:0]         cw,
    output logic [T_STATES-1:0] t_state,
    output logic                low_halt,
    output logic                illegal_op
);

    // Control word bit masks
    localparam logic [12:0] CW_CP = 13'h1000;
    localparam logic [12:0] CW_EP = 13'h0800;
    localparam logic [12:0] CW_LM = 13'h0400;
    localparam logic [12:0] CW_CE = 13'h0200;
    localparam logic [12:0] CW_LI = 13'h0100;
    localparam logic [12:0] CW_EI = 13'h0080;
    localparam logic [12:0] CW_LA = 13'h0040;
    localparam logic [12:0] CW_EA = 13'h0020;
    localparam logic [12:0] CW_SU = 13'h0010;
    localparam logic [12:0] CW_EU = 13'h0008;
    localparam logic [12:0] CW_LB = 13'h0004;
    localparam logic [12:0] CW_LO = 13'h0002;
    localparam logic [12:0] CW_LP = 13'h0001;

    // Opcodes, zero-extended to the configured opcode width
    localparam logic [OP_W-1:0] OP_LDA = OP_W'(4'b0000);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'b0001);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'b0010);
    localparam logic [OP_W-1:0] OP_JMP = OP_W'(4'b0011);
    localparam logic [OP_W-1:0] OP_OUT = OP_W'(4'b1110);
    localparam logic [OP_W-1:0] OP_HLT = OP_W'(4'b1111);

    typedef enum logic {
        MODE_RUN  = 1'b0,
        MODE_HALT = 1'b1
    } mode_t;

    mode_t               mode_q, mode_d;
    logic [T_STATES-1:0] t_next;
    logic                step_q;
    logic                step_rise;
    logic                halt_now;
    logic                advance;

    // Only the first six T-states carry work; later ring positions see an
    // all-zero slice here and therefore decode to NOP.
    function automatic logic [12:0] decode_cw(input logic [5:0]      ts,
                                              input logic [OP_W-1:0] op);
        logic [12:0] w;
        w = '0;
        if (ts[0]) begin
            w = CW_EP | CW_LM;
        end else if (ts[1]) begin
            w = CW_CP;
        end else if (ts[2]) begin
            w = CW_CE | CW_LI;
        end else if (ts[3]) begin
            case (op)
                OP_LDA, OP_ADD, OP_SUB: w = CW_EI | CW_LM;
                OP_JMP:                 w = CW_EI | CW_LP;
                OP_OUT:                 w = CW_EA | CW_LO;
                default:                w = '0;
            endcase
        end else if (ts[4]) begin
            case (op)
                OP_LDA:         w = CW_CE | CW_LA;
                OP_ADD, OP_SUB: w = CW_CE | CW_LB;
                default:        w = '0;
            endcase
        end else if (ts[5]) begin
            case (op)
                OP_ADD:  w = CW_EU | CW_LA;
                OP_SUB:  w = CW_SU | CW_EU | CW_LA;
                default: w = '0;
            endcase
        end
        return w;
    endfunction

    function automatic logic op_defined(input logic [OP_W-1:0] op);
        logic d;
        case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_JMP, OP_OUT, OP_HLT: d = 1'b1;
            default:                                        d = 1'b0;
        endcase
        return d;
    endfunction

    // Step request edge detector; runs whether or not step mode is enabled
    // so that enabling step mode with step already high does not advance.
    always_ff @(posedge clk or negedge low_clr) begin
        if (!low_clr) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    assign step_rise = step & ~step_q;

    // State register: halt mode and the T-state ring
    always_ff @(posedge clk or negedge low_clr) begin
        if (!low_clr) begin
            mode_q  <= MODE_RUN;
            t_state <= T_STATES'(1);
        end else begin
            mode_q  <= mode_d;
            t_state <= t_next;
        end
    end

    // Next-state logic. HLT is recognised combinationally in T4 so the ring
    // never leaves T4 and low_halt drops in the very cycle T4 is reached;
    // the mode register then keeps the machine halted even if the opcode
    // changes afterwards.
    always_comb begin
        mode_d   = mode_q;
        t_next   = t_state;
        halt_now = (mode_q == MODE_HALT) || (t_state[3] && (op_code == OP_HLT));
        advance  = 1'b0;

        if (halt_now) begin
            mode_d = MODE_HALT;
        end else begin
            advance = !step_en || step_rise;
        end

        if (advance) begin
            t_next = {t_state[T_STATES-2:0], t_state[T_STATES-1]};
        end
    end

    // Outputs
    assign cw         = halt_now ? 13'h0000 : decode_cw(t_state[5:0], op_code);
    assign low_halt   = ~halt_now;
    assign illegal_op = t_state[3] & ~halt_now & ~op_defined(op_code);

endmodule

// File: tb/tb_sap_control_sequencer.sv
module tb_sap_control_sequencer;

    logic        clk;
    logic        low_clr;
    logic [3:0]  op_code;
    logic        step_en;
    logic        step;

    logic [12:0] cw;
    logic [5:0]  t_state;
    logic        low_halt;
    logic        illegal_op;

    logic [12:0] cw8;
    logic [7:0]  t_state8;
    logic        low_halt8;
    logic        illegal_op8;

    int total;
    int bad;

    sap_control_sequencer #(.OP_W(4), .T_STATES(6)) u_dut6 (
        .clk        (clk),
        .low_clr    (low_clr),
        .op_code    (op_code),
        .step_en    (step_en),
        .step       (step),
        .cw         (cw),
        .t_state    (t_state),
        .low_halt   (low_halt),
        .illegal_op (illegal_op)
    );

    sap_control_sequencer #(.OP_W(4), .T_STATES(8)) u_dut8 (
        .clk        (clk),
        .low_clr    (low_clr),
        .op_code    (op_code),
        .step_en    (step_en),
        .step       (step),
        .cw         (cw8),
        .t_state    (t_state8),
        .low_halt   (low_halt8),
        .illegal_op (illegal_op8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]         op;
        logic [0:5][12:0]   w;
        logic               ill;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Move to 1 time unit after the next falling edge: drive and sample point
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        low_clr = 1'b0;
        tick();
        low_clr = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total   = 0;
        bad     = 0;
        low_clr = 1'b0;
        op_code = 4'h0;
        step_en = 1'b0;
        step    = 1'b0;

        vecs[0] = '{op: 4'h0, w: {13'h0C00, 13'h1000, 13'h0300, 13'h0480, 13'h0240, 13'h0000}, ill: 1'b0};
        vecs[1] = '{op: 4'h1, w: {13'h0C00, 13'h1000, 13'h0300, 13'h0480, 13'h0204, 13'h0048}, ill: 1'b0};
        vecs[2] = '{op: 4'h2, w: {13'h0C00, 13'h1000, 13'h0300, 13'h0480, 13'h0204, 13'h0058}, ill: 1'b0};
        vecs[3] = '{op: 4'h3, w: {13'h0C00, 13'h1000, 13'h0300, 13'h0081, 13'h0000, 13'h0000}, ill: 1'b0};
        vecs[4] = '{op: 4'hE, w: {13'h0C00, 13'h1000, 13'h0300, 13'h0022, 13'h0000, 13'h0000}, ill: 1'b0};
        vecs[5] = '{op: 4'h5, w: {13'h0C00, 13'h1000, 13'h0300, 13'h0000, 13'h0000, 13'h0000}, ill: 1'b1};
        vecs[6] = '{op: 4'h9, w: {13'h0C00, 13'h1000, 13'h0300, 13'h0000, 13'h0000, 13'h0000}, ill: 1'b1};

        // Reset state while low_clr is held low
        tick();
        check("reset t_state",    32'(t_state),    32'h01);
        check("reset cw",         32'(cw),         32'h0C00);
        check("reset low_halt",   32'(low_halt),   32'h1);
        check("reset illegal_op", 32'(illegal_op), 32'h0);
        check("reset t_state8",   32'(t_state8),   32'h01);
        low_clr = 1'b1;

        // Free-run each opcode through a full instruction on both ring sizes
        for (int i = 0; i < 7; i++) begin
            op_code = vecs[i].op;
            do_reset();
            for (int t = 0; t < 6; t++) begin
                check($sformatf("v%0d T%0d cw", i, t + 1), 32'(cw), 32'(vecs[i].w[t]));
                check($sformatf("v%0d T%0d t_state", i, t + 1), 32'(t_state), 32'(1) << t);
                check($sformatf("v%0d T%0d illegal_op", i, t + 1), 32'(illegal_op),
                      (t == 3) ? 32'(vecs[i].ill) : 32'h0);
                check($sformatf("v%0d T%0d low_halt", i, t + 1), 32'(low_halt), 32'h1);
                check($sformatf("v%0d T%0d cw8", i, t + 1), 32'(cw8), 32'(vecs[i].w[t]));
                check($sformatf("v%0d T%0d t_state8", i, t + 1), 32'(t_state8), 32'(1) << t);
                tick();
            end
            check($sformatf("v%0d wrap t_state", i), 32'(t_state), 32'h01);
            check($sformatf("v%0d wrap cw", i), 32'(cw), 32'h0C00);
            check($sformatf("v%0d T7 t_state8", i), 32'(t_state8), 32'h40);
            check($sformatf("v%0d T7 cw8", i), 32'(cw8), 32'h0000);
            tick();
            check($sformatf("v%0d T8 t_state8", i), 32'(t_state8), 32'h80);
            check($sformatf("v%0d T8 cw8", i), 32'(cw8), 32'h0000);
            tick();
            check($sformatf("v%0d wrap t_state8", i), 32'(t_state8), 32'h01);
            check($sformatf("v%0d wrap cw8", i), 32'(cw8), 32'h0C00);
        end

        // HLT: freeze at T4 regardless of later opcode and step activity
        op_code = 4'hF;
        do_reset();
        tick();
        tick();
        tick();
        check("hlt T4 t_state", 32'(t_state), 32'h08);
        check("hlt T4 cw", 32'(cw), 32'h0000);
        check("hlt T4 illegal_op", 32'(illegal_op), 32'h0);
        tick();
        op_code = 4'h0;
        for (int k = 0; k < 20; k++) begin
            step = k[0];
            check($sformatf("hlt c%0d t_state", k), 32'(t_state), 32'h08);
            check($sformatf("hlt c%0d cw", k), 32'(cw), 32'h0000);
            check($sformatf("hlt c%0d low_halt", k), 32'(low_halt), 32'h0);
            check($sformatf("hlt c%0d t_state8", k), 32'(t_state8), 32'h08);
            tick();
        end
        step = 1'b0;
        low_clr = 1'b0;
        #1;
        check("hlt clr t_state", 32'(t_state), 32'h01);
        check("hlt clr low_halt", 32'(low_halt), 32'h1);
        tick();
        low_clr = 1'b1;
        tick();
        check("hlt resume t_state", 32'(t_state), 32'h02);
        check("hlt resume cw", 32'(cw), 32'h1000);

        // Single-step: a held level advances once, each fresh rise advances once
        op_code = 4'h0;
        step_en = 1'b1;
        step    = 1'b0;
        do_reset();
        tick();
        check("step idle t_state", 32'(t_state), 32'h01);
        step = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check("step held t_state", 32'(t_state), 32'h02);
        check("step held cw", 32'(cw), 32'h1000);
        for (int k = 0; k < 3; k++) begin
            step = 1'b0;
            tick();
            step = 1'b1;
            tick();
        end
        check("step x3 t_state", 32'(t_state), 32'h10);
        check("step x3 cw", 32'(cw), 32'h0240);
        step_en = 1'b0;
        tick();
        check("step off t_state", 32'(t_state), 32'h20);

        // HLT reached through single-stepping
        op_code = 4'hF;
        step_en = 1'b1;
        step    = 1'b0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            tick();
        end
        check("step hlt t_state", 32'(t_state), 32'h08);
        check("step hlt low_halt", 32'(low_halt), 32'h0);
        check("step hlt cw", 32'(cw), 32'h0000);
        step_en = 1'b0;

        // Asynchronous clear in the middle of an instruction (T5)
        op_code = 4'h0;
        do_reset();
        for (int k = 0; k < 4; k++) tick();
        check("mid T5 t_state8", 32'(t_state8), 32'h10);
        #2;
        low_clr = 1'b0;
        #1;
        check("mid clr t_state8", 32'(t_state8), 32'h01);
        check("mid clr t_state", 32'(t_state), 32'h01);
        check("mid clr cw", 32'(cw), 32'h0C00);
        tick();
        low_clr = 1'b1;
        tick();
        check("mid after t_state8", 32'(t_state8), 32'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
